// File: rtl/debug_responder.sv
// Debug port target: decodes register accesses from the debug controller, runs
// halt/run/step on the CPU and 32-bit debug memory accesses over a bus-master port.
module debug_responder #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter logic [31:0] ID_VALUE    = 32'h4f4c4431
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_dbg_addr,
    input  logic [31:0] i_dbg_din,
    output logic [31:0] o_dbg_dout,
    input  logic        i_dbg_wr_en,
    input  logic        i_dbg_req,
    output logic        o_dbg_ack,
    output logic        o_cpu_halt,
    output logic        o_cpu_step,
    input  logic        i_cpu_stopped,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    output logic        o_mem_access,
    output logic        o_mem_wr_en,
    input  logic        i_mem_ack
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_ACK, S_HALT_WAIT, S_STEP_PULSE, S_STEP_WAIT, S_MEM, S_DONE
    } state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_sel;
    logic        r_wr;
    logic [31:0] r_wdata;
    logic [31:0] r_dout;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_error;
    logic        r_halt;
    logic        r_mem_wr;
    logic        r_step_first;
    logic [CW-1:0] r_cnt;

    logic        w_cmd_wr;
    logic [2:0]  w_cmd;
    logic        w_timeout;
    logic        w_busy;
    logic        w_mem_act;
    logic [31:0] w_rd_mux;

    assign w_cmd_wr  = i_dbg_req & i_dbg_wr_en & (i_dbg_addr == 2'd0);
    assign w_cmd     = i_dbg_din[2:0];
    assign w_timeout = (r_cnt == TO_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_dbg_req) begin
                    if (w_cmd_wr) begin
                        case (w_cmd)
                            3'd0:    w_next = S_HALT_WAIT;
                            3'd2:    w_next = i_cpu_stopped ? S_STEP_PULSE : S_ACK;
                            3'd3,
                            3'd4:    w_next = S_MEM;
                            default: w_next = S_ACK;
                        endcase
                    end else begin
                        w_next = S_ACK;
                    end
                end
            end
            S_ACK:        w_next = S_DONE;
            S_HALT_WAIT:  if (i_cpu_stopped) w_next = S_ACK;
            S_STEP_PULSE: w_next = S_STEP_WAIT;
            // The CPU may still report stopped in the cycle right after the pulse.
            S_STEP_WAIT:  if (!r_step_first && i_cpu_stopped) w_next = S_ACK;
            S_MEM:        if (i_mem_ack || w_timeout) w_next = S_ACK;
            S_DONE:       if (!i_dbg_req) w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_dbg_ack  = (r_state == S_ACK);
        o_cpu_step = (r_state == S_STEP_PULSE);
        w_mem_act  = (r_state == S_MEM);
        w_busy     = (r_state != S_IDLE);
    end

    always_comb begin
        case (i_dbg_addr)
            2'd0:    w_rd_mux = {29'b0, r_error, w_busy, i_cpu_stopped};
            2'd1:    w_rd_mux = r_addr;
            2'd2:    w_rd_mux = r_data;
            default: w_rd_mux = ID_VALUE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel        <= '0;
            r_wr         <= 1'b0;
            r_wdata      <= '0;
            r_dout       <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_error      <= 1'b0;
            r_halt       <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_step_first <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_step_first <= (r_state == S_STEP_PULSE);
            r_cnt        <= w_mem_act ? r_cnt + 1'b1 : '0;
            if (r_state == S_IDLE && i_dbg_req) begin
                r_sel   <= i_dbg_addr;
                r_wr    <= i_dbg_wr_en;
                r_wdata <= i_dbg_din;
                if (!i_dbg_wr_en) r_dout <= w_rd_mux;
                if (w_cmd_wr) begin
                    r_error <= (w_cmd > 3'd4) | ((w_cmd == 3'd2) & ~i_cpu_stopped);
                    if (w_cmd == 3'd0) r_halt <= 1'b1;
                    if (w_cmd == 3'd1) r_halt <= 1'b0;
                    if (w_cmd == 3'd3 || w_cmd == 3'd4) r_mem_wr <= (w_cmd == 3'd4);
                end
            end
            // Register writes land at the edge that ends the ack cycle.
            if (r_state == S_ACK && r_wr) begin
                if (r_sel == 2'd1) r_addr <= r_wdata;
                if (r_sel == 2'd2) r_data <= r_wdata;
            end
            if (w_mem_act) begin
                if (i_mem_ack) begin
                    if (!r_mem_wr) r_data <= i_mem_rdata;
                end else if (w_timeout) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    assign o_dbg_dout   = r_dout;
    assign o_cpu_halt   = r_halt;
    assign o_mem_access = w_mem_act;
    assign o_mem_wr_en  = w_mem_act & r_mem_wr;
    assign o_mem_addr   = w_mem_act ? r_addr : '0;
    assign o_mem_wdata  = w_mem_act ? r_data : '0;

endmodule

// File: tb/tb_debug_responder.sv
// Directed bench for debug_responder: table of register accesses plus
// hand-written command, memory, timeout and reset sequences.
module tb_debug_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  dbg_addr = '0;
    logic [31:0] dbg_din = '0;
    logic [31:0] dbg_dout;
    logic        dbg_wr_en = 1'b0;
    logic        dbg_req = 1'b0;
    logic        dbg_ack;
    logic        cpu_halt, cpu_step, cpu_stopped;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_access, mem_wr_en;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    debug_responder #(.MEM_TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_dbg_addr(dbg_addr), .i_dbg_din(dbg_din),
        .o_dbg_dout(dbg_dout), .i_dbg_wr_en(dbg_wr_en), .i_dbg_req(dbg_req),
        .o_dbg_ack(dbg_ack), .o_cpu_halt(cpu_halt), .o_cpu_step(cpu_step),
        .i_cpu_stopped(cpu_stopped), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_mem_access(mem_access), .o_mem_wr_en(mem_wr_en),
        .i_mem_ack(mem_ack)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory model: acks mem_delay cycles after access rises (0 = never).
    int          mem_delay = 0;
    int          mem_cnt = 0;
    int          rises = 0;
    logic        prev_acc = 1'b0;
    logic [31:0] mem_rd_val = '0;
    logic        seen_wr = 1'b0;
    logic [31:0] seen_addr = '0, seen_wdata = '0;
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_access) begin
            if (!prev_acc) rises++;
            mem_cnt++;
            seen_wr    = mem_wr_en;
            seen_addr  = mem_addr;
            seen_wdata = mem_wdata;
            if (mem_delay != 0 && mem_cnt == mem_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_rd_val;
            end
        end else begin
            mem_cnt = 0;
        end
        prev_acc = mem_access;
    end

    // CPU model: a step pulse drops cpu_stopped for step_drop cycles.
    int   step_drop = 0, drop_left = 0, steps = 0;
    logic step_busy = 1'b0, base_stopped = 1'b0;
    always @(negedge clk) begin
        if (cpu_step) begin
            steps++;
            if (step_drop > 0) begin
                step_busy = 1'b1;
                drop_left = step_drop;
            end
        end else if (drop_left > 0) begin
            drop_left--;
            if (drop_left == 0) step_busy = 1'b0;
        end
    end
    assign cpu_stopped = base_stopped & ~step_busy;

    int acks = 0;
    always @(negedge clk) if (dbg_ack) acks++;

    logic        ack_halt = 1'b0;
    logic [31:0] rd;
    int          lat;

    // Latency = negedges from request launch to the ack cycle; -1 if no ack.
    task automatic txn(input logic wr, input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] dout, output int l);
        bit got = 0;
        dbg_req = 1'b1; dbg_wr_en = wr; dbg_addr = a; dbg_din = d;
        l = 0; dout = '0;
        while (!got && l < 40) begin
            @(negedge clk);
            l++;
            if (dbg_ack) begin
                got = 1;
                dout = dbg_dout;
                ack_halt = cpu_halt;
            end
        end
        dbg_req = 1'b0;
        if (!got) l = -1;
        repeat (2) @(negedge clk);
    endtask

    task automatic cmd(input logic [2:0] c, input int exp_lat, input string nm);
        txn(1'b1, 2'd0, {29'b0, c}, rd, lat);
        check({nm, "_lat"}, lat, exp_lat);
    endtask

    task automatic rd_status(input logic [31:0] exp, input string nm);
        txn(1'b0, 2'd0, '0, rd, lat);
        check(nm, rd, exp);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];
    int   s0, r0, a0;

    initial begin
        vecs[0] = '{1'b0, 2'd3, 32'h0,        32'h4f4c4431};
        vecs[1] = '{1'b1, 2'd2, 32'hdeadbeef, 32'h0};
        vecs[2] = '{1'b0, 2'd2, 32'h0,        32'hdeadbeef};
        vecs[3] = '{1'b1, 2'd1, 32'h00000100, 32'h0};
        vecs[4] = '{1'b0, 2'd1, 32'h0,        32'h00000100};
        vecs[5] = '{1'b1, 2'd3, 32'h00000055, 32'h0};
        vecs[6] = '{1'b0, 2'd3, 32'h0,        32'h4f4c4431};
        vecs[7] = '{1'b0, 2'd0, 32'h0,        32'h0};

        repeat (3) @(negedge clk);
        check("rst_outs", {dbg_ack, cpu_halt, cpu_step, mem_access, mem_wr_en}, 0);
        check("rst_dout", dbg_dout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            txn(vecs[i].wr, vecs[i].addr, vecs[i].din, rd, lat);
            check($sformatf("vec%0d_lat", i), lat, 1);
            if (!vecs[i].wr) check($sformatf("vec%0d_dout", i), rd, vecs[i].exp);
        end

        // HALT, CPU stops 5 cycles later
        fork
            txn(1'b1, 2'd0, 32'd0, rd, lat);
            begin
                repeat (5) @(negedge clk);
                check("halt_level", cpu_halt, 1);
                base_stopped = 1'b1;
            end
        join
        check("halt_lat", lat, 6);
        rd_status(32'h1, "status_halted");
        cmd(3'd1, 1, "run");
        check("run_halt_low", ack_halt, 0);
        cmd(3'd0, 2, "halt_stopped");
        check("halt_again", cpu_halt, 1);

        step_drop = 3;
        s0 = steps;
        cmd(3'd2, 5, "step");
        check("step_pulses", steps - s0, 1);
        rd_status(32'h1, "status_step");
        check("halt_persist", cpu_halt, 1);

        base_stopped = 1'b0;
        s0 = steps;
        cmd(3'd2, 1, "step_running");
        check("step_run_pulses", steps - s0, 0);
        rd_status(32'h4, "status_step_err");

        // Memory read / write
        mem_delay = 4; mem_rd_val = 32'h12345678; r0 = rises;
        cmd(3'd3, 5, "read32");
        check("read32_wr", seen_wr, 0);
        check("read32_addr", seen_addr, 32'h100);
        check("read32_rises", rises - r0, 1);
        txn(1'b0, 2'd2, '0, rd, lat);
        check("read32_data", rd, 32'h12345678);
        rd_status(32'h0, "status_read32");
        txn(1'b1, 2'd2, 32'hcafef00d, rd, lat);
        mem_delay = 2;
        cmd(3'd4, 3, "write32");
        check("write32_wr", seen_wr, 1);
        check("write32_wdata", seen_wdata, 32'hcafef00d);

        // Timeout with MEM_TIMEOUT = 8
        mem_delay = 0; r0 = rises;
        cmd(3'd3, 10, "timeout");
        check("timeout_rises", rises - r0, 1);
        rd_status(32'h4, "status_timeout");
        txn(1'b0, 2'd2, '0, rd, lat);
        check("timeout_data", rd, 32'hcafef00d);
        cmd(3'd1, 1, "run_clear");
        rd_status(32'h0, "status_cleared");
        cmd(3'd7, 1, "illegal");
        rd_status(32'h4, "status_illegal");

        // Held request gets exactly one ack
        a0 = acks;
        dbg_req = 1'b1; dbg_wr_en = 1'b0; dbg_addr = 2'd3;
        repeat (10) @(negedge clk);
        check("held_acks", acks - a0, 1);
        dbg_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during MEM
        mem_delay = 0; a0 = acks;
        dbg_req = 1'b1; dbg_wr_en = 1'b1; dbg_addr = 2'd0; dbg_din = 32'd3;
        repeat (2) @(negedge clk);
        check("mem_before_rst", mem_access, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mem_outs", {dbg_ack, cpu_halt, cpu_step, mem_access, mem_wr_en}, 0);
        check("rst_mem_addr", mem_addr, 0);
        dbg_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mem_noack", acks - a0, 0);

        // Reset during HALT_WAIT
        a0 = acks;
        dbg_req = 1'b1; dbg_wr_en = 1'b1; dbg_addr = 2'd0; dbg_din = 32'd0;
        repeat (2) @(negedge clk);
        check("hw_before_rst", cpu_halt, 1);
        rst_n = 1'b0;
        #1;
        check("rst_hw_outs", {dbg_ack, cpu_halt, cpu_step, mem_access, mem_wr_en}, 0);
        dbg_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_hw_noack", acks - a0, 0);
        txn(1'b0, 2'd1, '0, rd, lat);
        check("rst_addr_cleared", rd, 0);
        rd_status(32'h0, "status_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
